// File: rtl/imem_access_arbiter.sv
// Arbitrates a single-ported instruction memory between the CPU fetch port and the loader/debug port.
// Optional macro IMEM_ARB_PERF_EN adds a saturating conflict_cnt output.
module imem_access_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    input  logic              l_done,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              boot_busy
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic {BOOT, RUN} state_t;
    typedef enum logic {FETCH, LOADER} req_t;

    state_t            state, state_nxt;
    req_t              rr_last, rr_nxt;
    logic [ADDR_W-1:0] last_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            rr_last <= FETCH;
        end else begin
            state   <= state_nxt;
            rr_last <= rr_nxt;
        end
    end

    // rr_last records the winner of the most recent conflict; the other side wins the next one.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_last;
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        case (state)
            BOOT: begin
                l_gnt = l_req;
                if (l_done)
                    state_nxt = RUN;
            end
            RUN: begin
                if (f_req && l_req) begin
                    if (rr_last == FETCH) begin
                        l_gnt  = 1'b1;
                        rr_nxt = LOADER;
                    end else begin
                        f_gnt  = 1'b1;
                        rr_nxt = FETCH;
                    end
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req;
                end
            end
        endcase
    end

    always_comb begin
        mem_addr = last_addr;
        if (f_gnt)
            mem_addr = f_addr;
        else if (l_gnt)
            mem_addr = l_addr;
    end

    assign mem_we    = l_gnt & l_we;
    assign mem_wdata = l_wdata;
    assign boot_busy = (state == BOOT);

    // Memory read data is asynchronous, so it is captured at the edge that closes the grant cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr <= '0;
            f_rvalid  <= 1'b0;
            f_rdata   <= '0;
            l_rvalid  <= 1'b0;
            l_rdata   <= '0;
        end else begin
            if (f_gnt || l_gnt)
                last_addr <= mem_addr;
            f_rvalid <= f_gnt;
            l_rvalid <= l_gnt & ~l_we;
            if (f_gnt)
                f_rdata <= mem_rdata;
            if (l_gnt && !l_we)
                l_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(f_gnt && l_gnt));
            assert (32'(MEM_DEPTH) == (32'd1 << IDX_W));
        end
    end

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            conflict_cnt <= '0;
        else if (state == RUN && f_req && l_req && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif

endmodule
